// File: rtl/tx_packet_buffer.sv
// Packet byte buffer feeding the Maple bus transmitter: the host loads payload bytes,
// the block streams them out on tx_next strobes and appends an XOR checksum byte.
module tx_packet_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  input  logic          send,
  output logic          ready,
  output logic          done,
  output logic [AW:0]   count,
  output logic          tx_enable,
  input  logic          tx_busy,
  input  logic          tx_next,
  output logic [7:0]    tx_data
);

  typedef enum logic [1:0] {FILL, LAUNCH, STREAM, DONE} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   sent;
  logic [7:0]    csum;

  logic          wr_accept;
  logic [AW:0]   remaining;

  assign wr_accept = (state == FILL) && wr_en && (cnt < DEPTH_C);
  // Bytes still to go including the checksum; cnt <= DEPTH so cnt+1 fits in AW+1 bits.
  assign remaining = cnt + ONE_C - sent;

  // NOTE: the payload array carries no reset; stale contents are never read because
  // rd_ptr only advances over bytes written since the last clear.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      sent   <= '0;
      csum   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (wr_accept) begin
            wr_ptr <= wr_ptr + AW'(1);
            cnt    <= cnt + ONE_C;
            csum   <= csum ^ wr_data;
          end
          if (send && (cnt != '0 || wr_accept)) state <= LAUNCH;
        end
        LAUNCH: begin
          if (tx_busy) state <= STREAM;
        end
        STREAM: begin
          if (tx_next && sent <= cnt) begin
            sent <= sent + ONE_C;
            if (sent < cnt) rd_ptr <= rd_ptr + AW'(1);
          end
          if (!tx_busy) state <= DONE;
        end
        DONE: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          cnt    <= '0;
          sent   <= '0;
          csum   <= '0;
          state  <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

  // Transmitter-facing outputs are decoded from state so that reset drops tx_enable at
  // once and enable falls in the same cycle the checksum byte is presented.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    tx_enable = 1'b0;
    tx_data   = 8'h00;
    case (state)
      LAUNCH: begin
        tx_enable = 1'b1;
        tx_data   = (sent < cnt) ? mem[rd_ptr] : csum;
      end
      STREAM: begin
        tx_enable = remaining > ONE_C;
        tx_data   = (sent < cnt) ? mem[rd_ptr] : csum;
      end
      default: ;
    endcase
  end

  assign ready = (state == FILL);
  assign full  = (state != FILL) || (cnt == DEPTH_C);
  assign done  = (state == DONE);
  assign count = cnt;

endmodule

// File: tb/tb_tx_packet_buffer.sv
// Directed bench for tx_packet_buffer: the driver plays host and transmitter, a monitor
// compares every consumed tx_data byte against a queue of expected frame bytes.
module tb_tx_packet_buffer;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full;
  logic          send = 1'b0;
  logic          ready;
  logic          done;
  logic [AW:0]   count;
  logic          tx_enable;
  logic          tx_busy = 1'b0;
  logic          tx_next = 1'b0;
  logic [7:0]    tx_data;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [7:0]    exp_q[$];
  logic [7:0]    pkt[$];
  logic [7:0]    last_csum;

  tx_packet_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .send      (send),
    .ready     (ready),
    .done      (done),
    .count     (count),
    .tx_enable (tx_enable),
    .tx_busy   (tx_busy),
    .tx_next   (tx_next),
    .tx_data   (tx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a byte is consumed whenever the transmitter strobes tx_next while busy.
  always @(negedge clk) begin
    if (reset && tx_busy && tx_next) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected_byte: got 0x%0h, expected no byte", tx_data);
      end else begin
        check("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    pkt.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  // Turn the loaded payload into the expected frame: payload bytes then their XOR.
  task automatic issue_expected();
    last_csum = 8'h00;
    foreach (pkt[i]) begin
      exp_q.push_back(pkt[i]);
      last_csum = last_csum ^ pkt[i];
    end
    exp_q.push_back(last_csum);
    pkt.delete();
  endtask

  task automatic do_send();
    send = 1'b1;
    step();
    send = 1'b0;
    issue_expected();
    check("launch_enable", {31'h0, tx_enable}, 32'd1);
    check("launch_ready", {31'h0, ready}, 32'd0);
  endtask

  // Transmitter model: n payload bytes plus checksum, optional extra strobe after the
  // checksum, optional host write attempted mid-stream.
  task automatic transmit(input int n, input bit extra, input bit wr_mid);
    tx_busy = 1'b1;
    step();
    for (int i = 0; i <= n; i++) begin
      check($sformatf("enable_byte%0d", i), {31'h0, tx_enable}, (i < n) ? 32'd1 : 32'd0);
      tx_next = 1'b1;
      if (wr_mid && i == 1) begin
        wr_en   = 1'b1;
        wr_data = 8'hFF;
      end
      step();
      tx_next = 1'b0;
      if (wr_mid && i == 1) begin
        wr_en = 1'b0;
        check("stream_count_frozen", {23'h0, count}, n);
        check("stream_full", {31'h0, full}, 32'd1);
      end
      step();
    end
    check("enable_after_csum", {31'h0, tx_enable}, 32'd0);
    check("csum_hold", {24'h0, tx_data}, {24'h0, last_csum});
    if (extra) begin
      exp_q.push_back(last_csum);
      tx_next = 1'b1;
      step();
      tx_next = 1'b0;
      step();
    end
    tx_busy = 1'b0;
    step();
    check("done_pulse", {31'h0, done}, 32'd1);
    step();
    check("done_clear", {31'h0, done}, 32'd0);
    check("post_ready", {31'h0, ready}, 32'd1);
    check("post_count", {23'h0, count}, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_tx_enable", {31'h0, tx_enable}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_tx_data", {24'h0, tx_data}, 32'd0);
    check("rst_ready", {31'h0, ready}, 32'd1);
    check("rst_full", {31'h0, full}, 32'd0);
    check("rst_count", {23'h0, count}, 32'd0);
    #10 reset = 1'b1;
    step();

    // 1: four-byte frame, checksum 0x08
    load(8'h12); load(8'h34); load(8'h56); load(8'h78);
    check("t1_count", {23'h0, count}, 32'd4);
    do_send();
    check("t1_csum_model", {24'h0, last_csum}, 32'h08);
    transmit(4, 1'b0, 1'b0);

    // 2: single byte, checksum equals the byte
    load(8'hA5);
    do_send();
    transmit(1, 1'b0, 1'b0);

    // 3: fill to DEPTH, drop one extra, send DEPTH+1 bytes
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("t3_not_full", {31'h0, full}, 32'd0);
      load(8'((i * 7) ^ 8'h5A));
    end
    check("t3_full", {31'h0, full}, 32'd1);
    check("t3_count", {23'h0, count}, DEPTH);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    check("t3_drop_count", {23'h0, count}, DEPTH);
    do_send();
    transmit(DEPTH, 1'b0, 1'b0);

    // 4: send on empty buffer is ignored; write+send in one cycle launches
    send = 1'b1;
    step();
    send = 1'b0;
    check("t4_empty_enable", {31'h0, tx_enable}, 32'd0);
    check("t4_empty_ready", {31'h0, ready}, 32'd1);
    step();
    check("t4_empty_enable2", {31'h0, tx_enable}, 32'd0);
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    send    = 1'b1;
    pkt.push_back(8'h3C);
    step();
    wr_en = 1'b0;
    send  = 1'b0;
    issue_expected();
    check("t4_launch_enable", {31'h0, tx_enable}, 32'd1);
    transmit(1, 1'b0, 1'b0);

    // 5: reset mid-stream after two pops
    load(8'h01); load(8'h02); load(8'h03);
    do_send();
    tx_busy = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      tx_next = 1'b1;
      step();
      tx_next = 1'b0;
      step();
    end
    check("t5_enable_before", {31'h0, tx_enable}, 32'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_enable", {31'h0, tx_enable}, 32'd0);
    check("t5_rst_ready", {31'h0, ready}, 32'd1);
    check("t5_rst_count", {23'h0, count}, 32'd0);
    exp_q.delete();
    tx_busy = 1'b0;
    #2 reset = 1'b1;
    step();
    load(8'hC3); load(8'h81);
    do_send();
    transmit(2, 1'b0, 1'b0);

    // 6: extra tx_next after checksum and a host write during STREAM are ignored
    load(8'h11); load(8'h22); load(8'h44);
    do_send();
    transmit(3, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
